// File: rtl/bus_arbiter_split.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : bus_arbiter_split
// Brief    : Two-master arbiter for the serial system bus with support for one
//            outstanding split transaction. Issues one-hot grants, per-master
//            split indications and the bus-mux master select. All outputs are
//            registered.
// Revision : 1.0 - initial release
// ============================================================================
module bus_arbiter_split #(
  parameter int          ROUND_ROBIN  = 1,
  parameter int unsigned HANDOVER_GAP = 1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] breq,
  input  logic       ssplit,
  input  logic       split_ready,
  output logic [1:0] bgrant,
  output logic [1:0] msplit,
  output logic       msel,
  output logic       bus_busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Last GAP count value before returning to IDLE (GAP lasts HANDOVER_GAP cycles).
  localparam logic [2:0] c_gap_last = (HANDOVER_GAP == 0) ? 3'd0 : 3'(HANDOVER_GAP - 1);

  state_t     r_state,         state_d;
  logic [1:0] r_bgrant,        bgrant_d;
  logic [1:0] r_msplit,        msplit_d;
  logic       r_msel,          msel_d;
  logic       r_busy,          busy_d;
  logic       r_last_owner,    last_owner_d;
  logic       r_split_pending, split_pending_d;
  logic       r_split_owner,   split_owner_d;
  logic       r_resume,        resume_d;
  logic [2:0] r_gap_cnt,       gap_cnt_d;

  logic [1:0] w_elig;
  logic       w_pick;
  logic       w_end;

  // A master parked in a split is not eligible for a normal grant.
  assign w_elig[0] = breq[0] && !(r_split_pending && (r_split_owner == 1'b0));
  assign w_elig[1] = breq[1] && !(r_split_pending && (r_split_owner == 1'b1));

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state         <= ST_IDLE;
      r_bgrant        <= 2'b00;
      r_msplit        <= 2'b00;
      r_msel          <= 1'b0;
      r_busy          <= 1'b0;
      r_last_owner    <= 1'b1;
      r_split_pending <= 1'b0;
      r_split_owner   <= 1'b0;
      r_resume        <= 1'b0;
      r_gap_cnt       <= 3'd0;
    end else begin
      r_state         <= state_d;
      r_bgrant        <= bgrant_d;
      r_msplit        <= msplit_d;
      r_msel          <= msel_d;
      r_busy          <= busy_d;
      r_last_owner    <= last_owner_d;
      r_split_pending <= split_pending_d;
      r_split_owner   <= split_owner_d;
      r_resume        <= resume_d;
      r_gap_cnt       <= gap_cnt_d;
    end
  end

  // Next-state logic: arbitration, release/split handling, split bookkeeping.
  always_comb begin
    state_d         = r_state;
    bgrant_d        = r_bgrant;
    msplit_d        = r_msplit;
    msel_d          = r_msel;
    busy_d          = r_busy;
    last_owner_d    = r_last_owner;
    split_pending_d = r_split_pending;
    split_owner_d   = r_split_owner;
    resume_d        = r_resume;
    gap_cnt_d       = r_gap_cnt;
    w_pick          = 1'b0;
    w_end           = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (r_split_pending && r_resume && breq[r_split_owner]) begin
          // Returning split master has top priority.
          bgrant_d                = r_split_owner ? 2'b10 : 2'b01;
          msel_d                  = r_split_owner;
          busy_d                  = 1'b1;
          msplit_d[r_split_owner] = 1'b0;
          split_pending_d         = 1'b0;
          resume_d                = 1'b0;
          state_d                 = ST_BUSY;
        end else if (|w_elig) begin
          if (w_elig == 2'b11)
            w_pick = (ROUND_ROBIN != 0) ? ~r_last_owner : 1'b0;
          else
            w_pick = w_elig[1];
          bgrant_d = w_pick ? 2'b10 : 2'b01;
          msel_d   = w_pick;
          busy_d   = 1'b1;
          state_d  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (!breq[r_msel]) begin
          // Release beats a coincident split request.
          w_end = 1'b1;
        end else if (ssplit && !r_split_pending) begin
          w_end                   = 1'b1;
          split_pending_d         = 1'b1;
          split_owner_d           = r_msel;
          msplit_d[r_msel]        = 1'b1;
        end
      end
      ST_GAP: begin
        if (r_gap_cnt >= c_gap_last) begin
          gap_cnt_d = 3'd0;
          state_d   = ST_IDLE;
        end else begin
          gap_cnt_d = r_gap_cnt + 3'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (w_end) begin
      bgrant_d     = 2'b00;
      busy_d       = 1'b0;
      last_owner_d = r_msel;
      gap_cnt_d    = 3'd0;
      state_d      = (HANDOVER_GAP == 0) ? ST_IDLE : ST_GAP;
    end

    // Split master gave up waiting: drop the split entirely.
    if (r_split_pending && !breq[r_split_owner]) begin
      split_pending_d         = 1'b0;
      resume_d                = 1'b0;
      msplit_d[r_split_owner] = 1'b0;
    end

    // Data-ready only matters while a split is (or is becoming) outstanding.
    if (split_ready && split_pending_d)
      resume_d = 1'b1;
  end

  assign bgrant   = r_bgrant;
  assign msplit   = r_msplit;
  assign msel     = r_msel;
  assign bus_busy = r_busy;

endmodule
`default_nettype wire
